// File: rtl/muldiv_ctrl_if.sv
// EX-stage bundle for the mult/div sequencer: launch, mthi/mtlo writes, status and HI/LO.
// MULDIV_DIV0_EN adds the div0 flag that accompanies done on a short-circuited divide by zero.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MULDIV_DIV0_EN
  logic             div0;
`endif

  modport master (
    output start, op, a, b, cancel, wr_hi, wr_lo, wdata,
`ifdef MULDIV_DIV0_EN
    input  div0,
`endif
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, wr_hi, wr_lo, wdata,
`ifdef MULDIV_DIV0_EN
    output div0,
`endif
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Bit-serial mult/multu/div/divu sequencer owning HI/LO; stalls the pipeline while busy.
// MULDIV_DIV0_EN: divide by zero bypasses CALC and pulses div0 together with done.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  muldiv_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [4:0] OP_MULT  = 5'b10011;
  localparam logic [4:0] OP_MULTU = 5'b10101;
  localparam logic [4:0] OP_DIV   = 5'b10110;
  localparam logic [4:0] OP_DIVU  = 5'b10111;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nxt;

  logic [2*WIDTH-1:0] acc, acc_step, acc_fix;
  logic [WIDTH-1:0]   opnd, hi_q, lo_q, abs_a, abs_b, div_diff;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     mul_sum, div_top;
  logic               is_div, neg_q, neg_r, fix_last, done_q;
  logic               op_valid, op_div, op_signed, launch, div0_launch, no_borrow;
`ifdef MULDIV_DIV0_EN
  logic               div0_pend, div0_q;
`endif

  always_comb begin
    op_valid  = bus.op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    op_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    abs_a     = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b     = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    launch    = bus.start && op_valid && !bus.cancel && (state == IDLE);
`ifdef MULDIV_DIV0_EN
    div0_launch = launch && op_div && (bus.b == '0);
`else
    div0_launch = 1'b0;
`endif
  end

  // One iteration: mul adds into the upper half then shifts right; div shifts the
  // remainder:quotient pair left and keeps the trial subtraction when it does not borrow.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    div_top   = acc[2*WIDTH-1:WIDTH-1];
    no_borrow = div_top >= {1'b0, opnd};
    div_diff  = div_top[WIDTH-1:0] - opnd;
    if (is_div)
      acc_step = no_borrow ? {div_diff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
    else
      acc_step = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    if (is_div)
      acc_fix = {neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH],
                 neg_q ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0]};
    else
      acc_fix = neg_q ? -acc : acc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = div0_launch ? FIX : CALC;
      CALC:    if (bus.cancel) state_nxt = IDLE;
               else if (cnt == '0) state_nxt = FIX;
      FIX:     if (bus.cancel || fix_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FIX spends one cycle on sign correction and a second on the HI/LO commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      opnd     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      fix_last <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULDIV_DIV0_EN
      div0_pend <= 1'b0;
      div0_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MULDIV_DIV0_EN
      div0_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.wr_hi) hi_q <= bus.wdata;
          if (bus.wr_lo) lo_q <= bus.wdata;
          if (launch) begin
            cnt      <= CNT_W'(WIDTH - 1);
            is_div   <= op_div;
            fix_last <= 1'b0;
            neg_q    <= op_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r    <= op_signed && op_div && bus.a[WIDTH-1];
            if (op_div) begin
              acc  <= {{WIDTH{1'b0}}, abs_a};
              opnd <= abs_b;
            end else begin
              acc  <= {{WIDTH{1'b0}}, abs_b};
              opnd <= abs_a;
            end
`ifdef MULDIV_DIV0_EN
            div0_pend <= div0_launch;
            if (div0_launch) begin
              acc   <= {bus.a, {WIDTH{1'b1}}};
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end
`endif
          end
        end
        CALC: begin
          acc <= acc_step;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (!bus.cancel) begin
            if (!fix_last) begin
              acc      <= acc_fix;
              fix_last <= 1'b1;
            end else begin
              hi_q   <= acc[2*WIDTH-1:WIDTH];
              lo_q   <= acc[WIDTH-1:0];
              done_q <= 1'b1;
`ifdef MULDIV_DIV0_EN
              div0_q <= div0_pend;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.stall = (state != IDLE) || (bus.start && op_valid && (state == IDLE));
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
`ifdef MULDIV_DIV0_EN
  assign bus.div0  = div0_q;
`endif
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed and random checks of muldiv_ctrl against an arithmetic reference model of HI/LO.
// Honours MULDIV_DIV0_EN for divide-by-zero latency, result and the div0 flag.
module tb_muldiv_ctrl;
  localparam int W = 32;
  localparam logic [4:0] MULT  = 5'b10011;
  localparam logic [4:0] MULTU = 5'b10101;
  localparam logic [4:0] DIV   = 5'b10110;
  localparam logic [4:0] DIVU  = 5'b10111;
`ifdef MULDIV_DIV0_EN
  localparam bit DIV0_EN = 1'b1;
`else
  localparam bit DIV0_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_ctrl_if #(.WIDTH(W)) bus ();
  muldiv_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {hi, lo} straight from the arithmetic definition of each instruction.
  function automatic logic [63:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      MULT:  r = 64'(sx * sy);
      MULTU: r = {32'b0, x} * {32'b0, y};
      DIV:   if (y == 0) r = {x, (DIV0_EN || !x[31]) ? 32'hFFFF_FFFF : 32'h1};
             else        r = {32'(sx % sy), 32'(sx / sy)};
      DIVU:  if (y == 0) r = {x, 32'hFFFF_FFFF};
             else        r = {x % y, x / y};
      default: r = '0;
    endcase
    return r;
  endfunction

  // mode 0: plain; 1: start and mthi/mtlo poked while busy; 2: mthi/mtlo together with start
  task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int mode);
    logic [63:0] exp;
    int lat, n;
    exp = model(o, x, y);
    lat = (DIV0_EN && (o == DIV || o == DIVU) && y == 0) ? 2 : 34;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    if (mode == 2) begin
      bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = $urandom;
      m_hi = bus.wdata; m_lo = bus.wdata;
    end
    #1 check({tag, ".stall_launch"}, 64'(bus.stall), 64'd1);
    @(negedge clk);
    bus.start = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
    if (mode == 2) begin
      check({tag, ".hi_mthi"}, 64'(bus.hi), 64'(m_hi));
      check({tag, ".lo_mtlo"}, 64'(bus.lo), 64'(m_lo));
    end
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      check({tag, ".busy"}, 64'(bus.busy), 64'd1);
      check({tag, ".stall"}, 64'(bus.stall), 64'd1);
      if (mode == 1 && n == 5) begin
        bus.start = 1'b1; bus.op = MULTU; bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = $urandom;
      end
      if (mode == 1 && n == 6) begin
        bus.start = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        check({tag, ".hi_hold"}, 64'(bus.hi), 64'(m_hi));
        check({tag, ".lo_hold"}, 64'(bus.lo), 64'(m_lo));
      end
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(lat));
    check({tag, ".busy_end"}, 64'(bus.busy), 64'd0);
    check({tag, ".hi"}, 64'(bus.hi), 64'(exp[63:32]));
    check({tag, ".lo"}, 64'(bus.lo), 64'(exp[31:0]));
`ifdef MULDIV_DIV0_EN
    check({tag, ".div0"}, 64'(bus.div0), 64'(lat == 2));
`endif
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    @(negedge clk);
    check({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    check({tag, ".no_done"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [4:0] ops [4];
    logic [31:0] ra, rb;
    ops[0] = MULT; ops[1] = MULTU; ops[2] = DIV; ops[3] = DIVU;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wdata = '0;

    #1;
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.done", 64'(bus.done), 64'd0);
    check("rst.hi", 64'(bus.hi), 64'd0);
    check("rst.lo", 64'(bus.lo), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_op("mult_neg", MULT, 32'd7, 32'hFFFF_FFFD, 0);
    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mult_min", MULT, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 0);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_zero", DIVU, 32'd5, 32'd0, 0);
    run_op("div_zero_neg", DIV, 32'hFFFF_FFFB, 32'd0, 0);
    run_op("busy_poke", DIV, 32'h1234_5678, 32'hFFFF_FF00, 1);
    run_op("wr_with_start", MULTU, 32'hDEAD_BEEF, 32'h0000_1001, 2);

    // mthi, then a divide cancelled in CALC cycle 10
    @(negedge clk);
    bus.wr_hi = 1'b1; bus.wdata = 32'h0000_AAAA;
    @(negedge clk);
    bus.wr_hi = 1'b0; m_hi = 32'h0000_AAAA;
    check("mthi.hi", 64'(bus.hi), 64'(m_hi));
    bus.start = 1'b1; bus.op = DIV; bus.a = 32'd1000; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_calc.busy", 64'(bus.busy), 64'd0);
    check("cancel_calc.done", 64'(bus.done), 64'd0);
    check("cancel_calc.hi", 64'(bus.hi), 64'(m_hi));
    check("cancel_calc.lo", 64'(bus.lo), 64'(m_lo));
    expect_quiet("cancel_calc", 36);

    // cancel in the last FIX cycle still drops the result
    @(negedge clk);
    bus.start = 1'b1; bus.op = MULT; bus.a = 32'd99; bus.b = 32'd77;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (33) @(negedge clk);
    check("cancel_fix.busy_before", 64'(bus.busy), 64'd1);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_fix.busy", 64'(bus.busy), 64'd0);
    check("cancel_fix.done", 64'(bus.done), 64'd0);
    check("cancel_fix.hi", 64'(bus.hi), 64'(m_hi));
    check("cancel_fix.lo", 64'(bus.lo), 64'(m_lo));
    expect_quiet("cancel_fix", 4);

    // cancel in IDLE suppresses a coincident start; invalid op does nothing
    @(negedge clk);
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = MULTU;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    check("cancel_idle.busy", 64'(bus.busy), 64'd0);
    expect_quiet("cancel_idle", 36);
    bus.start = 1'b1; bus.op = 5'b00111;
    #1 check("badop.stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check("badop.busy", 64'(bus.busy), 64'd0);
    check("badop.hi", 64'(bus.hi), 64'(m_hi));

    // asynchronous reset during CALC cycle 20
    @(negedge clk);
    bus.start = 1'b1; bus.op = MULTU; bus.a = 32'hFFFF_0000; bus.b = 32'h0001_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    check("rst_mid.busy", 64'(bus.busy), 64'd0);
    check("rst_mid.done", 64'(bus.done), 64'd0);
    check("rst_mid.hi", 64'(bus.hi), 64'd0);
    check("rst_mid.lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("after_rst", MULT, 32'hFFFF_FF00, 32'd300, 0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 9);
        2:       rb = -$urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), ops[$urandom_range(0, 3)], ra, rb,
             (rb == 0) ? 0 : int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
